// File: rtl/vocab_encoder.sv
// rtl/vocab_encoder.sv - word-stream tokeniser: per-word vocabulary search, one token ID per word.
// Optional VOCAB_ENCODER_UNK_EN: emit UNK_ID on a vocabulary miss instead of skipping the word.
module vocab_encoder #(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = 4,
  parameter int VOCAB_ADDR_WIDTH = 6,
  parameter int TOK_LEN          = 4,
  parameter int VOCAB_SIZE       = 16,
  parameter int ID_WIDTH         = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_WIDTH-1:0]       in_addr,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic [VOCAB_ADDR_WIDTH-1:0] voc_addr,
  input  logic [DATA_WIDTH-1:0]       voc_data,
  output logic                        tok_valid,
  output logic [ID_WIDTH-1:0]         tok_id,
  input  logic                        tok_ready,
  output logic [ADDR_WIDTH:0]         tok_count
);

  localparam int IW = $clog2(TOK_LEN + 1);
  localparam logic [IW-1:0]         LAST_I   = IW'(TOK_LEN);
  localparam logic [ID_WIDTH-1:0]   LAST_K   = ID_WIDTH'(VOCAB_SIZE - 1);
  localparam logic [ID_WIDTH-1:0]   UNK_ID   = '1;
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = '1;
  localparam logic [ADDR_WIDTH:0]   CNT_MAX  = '1;
`ifdef VOCAB_ENCODER_UNK_EN
  localparam bit UNK_EN = 1'b1;
`else
  localparam bit UNK_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_WS_ISSUE, S_WS_CHK, S_C_ISSUE, S_C_CMP,
    S_EMIT, S_SK_ISSUE, S_SK_CHK, S_DONE
  } state_t;

  state_t state, next_state;
  logic [ADDR_WIDTH-1:0] wb;
  logic [IW-1:0]         idx;
  logic [ID_WIDTH-1:0]   k;
  logic [ADDR_WIDTH:0]   pos, next_pos;
  logic [DATA_WIDTH-1:0] in_char, voc_char;
  logic                  chars_eq, char_zero, in_zero, at_end, last_k;

  function automatic logic [VOCAB_ADDR_WIDTH-1:0] vaddr(input logic [ID_WIDTH-1:0] kk,
                                                        input logic [IW-1:0] ii);
    int a;
    a = int'(kk) * TOK_LEN + int'(ii);
    return a[VOCAB_ADDR_WIDTH-1:0];
  endfunction

  // Bit ADDR_WIDTH of pos flags a read past the end of memory: an implicit terminator.
  assign pos       = {1'b0, wb} + (ADDR_WIDTH+1)'(idx);
  assign next_pos  = {1'b0, wb} + (ADDR_WIDTH+1)'(idx + 1'b1);
  assign in_char   = pos[ADDR_WIDTH] ? '0 : in_data;
  assign voc_char  = (idx == LAST_I) ? '0 : voc_data;
  assign chars_eq  = (in_char == voc_char);
  assign char_zero = (in_char == '0);
  assign in_zero   = (in_data == '0);
  assign at_end    = (in_addr == MAX_ADDR);
  assign last_k    = (k == LAST_K);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (start) next_state = S_WS_ISSUE;
      S_WS_ISSUE: next_state = S_WS_CHK;
      S_WS_CHK:   next_state = in_zero ? S_DONE : S_C_ISSUE;
      S_C_ISSUE:  next_state = S_C_CMP;
      S_C_CMP: begin
        if (chars_eq)    next_state = char_zero ? S_EMIT : S_C_ISSUE;
        else if (last_k) next_state = UNK_EN ? S_EMIT : S_SK_ISSUE;
        else             next_state = S_C_ISSUE;
      end
      S_EMIT:     if (tok_ready) next_state = S_SK_ISSUE;
      S_SK_ISSUE: next_state = S_SK_CHK;
      S_SK_CHK:   next_state = at_end ? S_DONE : (in_zero ? S_WS_ISSUE : S_SK_ISSUE);
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE) && (state != S_DONE);
    done      = (state == S_DONE);
    tok_valid = (state == S_EMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_addr   <= '0;
      voc_addr  <= '0;
      tok_id    <= '0;
      tok_count <= '0;
      wb        <= '0;
      idx       <= '0;
      k         <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          in_addr   <= '0;
          voc_addr  <= '0;
          wb        <= '0;
          tok_count <= '0;
        end
        S_WS_CHK: begin
          idx      <= '0;
          k        <= '0;
          voc_addr <= '0;
        end
        S_C_CMP: begin
          if (chars_eq && !char_zero) begin
            idx      <= idx + 1'b1;
            in_addr  <= next_pos[ADDR_WIDTH] ? MAX_ADDR : next_pos[ADDR_WIDTH-1:0];
            voc_addr <= vaddr(k, idx + 1'b1);
          end else if (chars_eq) begin
            tok_id  <= k;
            in_addr <= wb;
          end else if (!last_k) begin
            k        <= k + 1'b1;
            idx      <= '0;
            in_addr  <= wb;
            voc_addr <= vaddr(k + 1'b1, '0);
          end else begin
            if (UNK_EN) tok_id <= UNK_ID;
            in_addr <= wb;
          end
        end
        S_EMIT: if (tok_ready && tok_count != CNT_MAX) tok_count <= tok_count + 1'b1;
        // Delimiter found: the next word begins right after it.
        S_SK_CHK: if (!at_end) begin
          in_addr <= in_addr + 1'b1;
          if (in_zero) wb <= in_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vocab_encoder.sv
// tb/tb_vocab_encoder.sv - self-checking bench for vocab_encoder against a string-level tokeniser model.
module tb_vocab_encoder;
  localparam int DW = 8, AW = 4, VAW = 6, TL = 4, VS = 16, IW = 5;
  localparam int UNK = 31;
`ifdef VOCAB_ENCODER_UNK_EN
  localparam bit UNK_EN = 1'b1;
`else
  localparam bit UNK_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, tok_ready = 1'b0;
  logic busy, done, tok_valid;
  logic [AW-1:0] in_addr;
  logic [VAW-1:0] voc_addr;
  logic [DW-1:0] in_data, voc_data;
  logic [IW-1:0] tok_id;
  logic [AW:0] tok_count;

  vocab_encoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VOCAB_ADDR_WIDTH(VAW),
                  .TOK_LEN(TL), .VOCAB_SIZE(VS), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data), .voc_addr(voc_addr), .voc_data(voc_data),
    .tok_valid(tok_valid), .tok_id(tok_id), .tok_ready(tok_ready), .tok_count(tok_count));

  always #5 clk = ~clk;

  logic [DW-1:0] in_mem [16];
  logic [DW-1:0] voc_mem[64];
  always @(posedge clk) begin
    in_data  <= in_mem[in_addr];
    voc_data <= voc_mem[voc_addr];
  end

  string vocab[VS];
  int checks = 0, errors = 0;
  int got_q[$], exp_q[$];
  int done_cnt, busy_bad, timed_out, addr_back0;

  function automatic void setup_vocab();
    vocab[0] = "hi"; vocab[1] = "cat"; vocab[2] = "dogs";
    for (int k = 3; k < VS; k++) begin
      string s;
      int len;
      s = "zzzz";
      len = $urandom_range(1, TL);
      s = s.substr(0, len - 1);
      for (int j = 0; j < len; j++) s.putc(j, 8'($urandom_range(112, 122)));
      vocab[k] = s;
    end
    for (int a = 0; a < 64; a++) voc_mem[a] = '0;
    for (int k = 0; k < VS; k++)
      for (int j = 0; j < vocab[k].len(); j++) voc_mem[k*TL + j] = vocab[k][j];
  endfunction

  // '.' stands for the 0 delimiter; bytes past the text are 0.
  function automatic void load_input(input string s);
    for (int j = 0; j < 16; j++) in_mem[j] = '0;
    for (int j = 0; j < s.len() && j < 16; j++) in_mem[j] = (s[j] == 8'h2e) ? 8'h00 : s[j];
  endfunction

  function automatic void build_expect();
    int p, e, id;
    string w;
    exp_q.delete();
    p = 0;
    while (p < 16 && in_mem[p] != 0) begin
      w = "";
      e = p;
      while (e < 16 && in_mem[e] != 0) begin
        w = {w, "?"};
        w.putc(w.len() - 1, in_mem[e]);
        e++;
      end
      id = -1;
      for (int k = 0; k < VS; k++) if (id < 0 && vocab[k] == w) id = k;
      if (id >= 0) exp_q.push_back(id);
      else if (UNK_EN) exp_q.push_back(UNK);
      p = e + 1;
    end
  endfunction

  task automatic run_stream(input bit rand_ready, input bit start_noise);
    bit seen_nz;
    got_q.delete();
    done_cnt = 0; busy_bad = 0; timed_out = 1; addr_back0 = 0; seen_nz = 0;
    @(negedge clk);
    start = 1'b1;
    tok_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      if (done) begin done_cnt++; timed_out = 0; break; end
      if (!busy) busy_bad++;
      if (in_addr != 0) seen_nz = 1;
      else if (seen_nz) addr_back0++;
      tok_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = start_noise ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (tok_valid && tok_ready) got_q.push_back(int'(tok_id));
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (tok_valid !== 1'b0) begin errors++; $display("FAIL reset_tok_valid got %b exp 0", tok_valid); end
    checks++; if (in_addr !== 4'd0) begin errors++; $display("FAIL reset_in_addr got %0d exp 0", in_addr); end
    checks++; if (voc_addr !== 6'd0) begin errors++; $display("FAIL reset_voc_addr got %0d exp 0", voc_addr); end
    checks++; if (tok_id !== 5'd0) begin errors++; $display("FAIL reset_tok_id got %0d exp 0", tok_id); end
    checks++; if (tok_count !== 5'd0) begin errors++; $display("FAIL reset_tok_count got %0d exp 0", tok_count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_encode();
    load_input("cat.hi..");
    run_stream(1'b0, 1'b0);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL basic_timeout got %0d exp 0", timed_out); end
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL basic_ntok got %0d exp 2", got_q.size()); end
    else begin
      checks++; if (got_q[0] != 1) begin errors++; $display("FAIL basic_tok0 got %0d exp 1", got_q[0]); end
      checks++; if (got_q[1] != 0) begin errors++; $display("FAIL basic_tok1 got %0d exp 0", got_q[1]); end
    end
    checks++; if (int'(tok_count) != 2) begin errors++; $display("FAIL basic_count got %0d exp 2", tok_count); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL basic_busy_low got %0d exp 0", busy_bad); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_miss_and_length();
    int exp_n;
    load_input("cow..");
    run_stream(1'b0, 1'b0);
    exp_n = UNK_EN ? 1 : 0;
    checks++; if (got_q.size() != exp_n) begin errors++; $display("FAIL miss_ntok got %0d exp %0d", got_q.size(), exp_n); end
    else if (UNK_EN) begin
      checks++; if (got_q[0] != UNK) begin errors++; $display("FAIL miss_unk got %0d exp %0d", got_q[0], UNK); end
    end
    checks++; if (int'(tok_count) != exp_n) begin errors++; $display("FAIL miss_count got %0d exp %0d", tok_count, exp_n); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL miss_done got %0d exp 1", done_cnt); end
    load_input("dogs.dogsx..");
    run_stream(1'b0, 1'b0);
    exp_n = UNK_EN ? 2 : 1;
    checks++; if (got_q.size() != exp_n) begin errors++; $display("FAIL len_ntok got %0d exp %0d", got_q.size(), exp_n); end
    else begin
      checks++; if (got_q[0] != 2) begin errors++; $display("FAIL len_exact got %0d exp 2", got_q[0]); end
      if (UNK_EN) begin
        checks++; if (got_q[1] != UNK) begin errors++; $display("FAIL len_overlong got %0d exp %0d", got_q[1], UNK); end
      end
    end
  endtask

  task automatic test_stall();
    logic [AW-1:0] held;
    int waited;
    load_input("hi..");
    @(negedge clk);
    tok_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!tok_valid && waited < 500) begin @(negedge clk); waited++; end
    checks++; if (tok_valid !== 1'b1) begin errors++; $display("FAIL stall_no_token got %b exp 1", tok_valid); end
    held = in_addr;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (tok_valid !== 1'b1 || tok_id !== 5'd0 || in_addr !== held) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got v=%b id=%0d a=%0d exp v=1 id=0 a=%0d", c, tok_valid, tok_id, in_addr, held);
      end
    end
    tok_ready = 1'b1;
    @(negedge clk);
    checks++; if (tok_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %b exp 0", tok_valid); end
    waited = 0;
    while (!done && waited < 500) begin @(negedge clk); waited++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got %b exp 1", done); end
    checks++; if (tok_count !== 5'd1) begin errors++; $display("FAIL stall_count got %0d exp 1", tok_count); end
  endtask

  task automatic test_wrap();
    int exp_n;
    load_input("abcdefghijklmnop");
    run_stream(1'b0, 1'b0);
    exp_n = UNK_EN ? 1 : 0;
    checks++; if (timed_out != 0) begin errors++; $display("FAIL wrap_timeout got %0d exp 0", timed_out); end
    checks++; if (got_q.size() != exp_n) begin errors++; $display("FAIL wrap_ntok got %0d exp %0d", got_q.size(), exp_n); end
    checks++; if (addr_back0 != 0) begin errors++; $display("FAIL wrap_addr_zero got %0d exp 0", addr_back0); end
    load_input("abcdefghijklmnhi");
    in_mem[13] = 8'h00;
    run_stream(1'b0, 1'b0);
    build_expect();
    checks++; if (got_q != exp_q) begin errors++; $display("FAIL wrap_cut_word got %p exp %p", got_q, exp_q); end
  endtask

  task automatic test_back_to_back();
    load_input("cat.hi..");
    run_stream(1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done got %b exp 0", busy); end
    checks++; if (tok_count !== 5'd2) begin errors++; $display("FAIL b2b_count_hold got %0d exp 2", tok_count); end
    load_input("hi.cat.dogs..");
    build_expect();
    run_stream(1'b1, 1'b1);
    checks++; if (got_q != exp_q) begin errors++; $display("FAIL b2b_tokens got %p exp %p", got_q, exp_q); end
  endtask

  task automatic test_reset_mid();
    int waited;
    load_input("cat.hi..");
    @(negedge clk);
    tok_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (voc_addr == 0 && waited < 200) begin @(negedge clk); waited++; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || tok_valid !== 1'b0 || tok_count !== 5'd0 || in_addr !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid got busy=%b v=%b cnt=%0d a=%0d exp 0 0 0 0", busy, tok_valid, tok_count, in_addr);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", done); end
    rst_n = 1'b1;
    load_input("hi..");
    run_stream(1'b0, 1'b0);
    checks++; if (got_q.size() != 1 || got_q[0] != 0) begin errors++; $display("FAIL rst_mid_restart got %p exp '{0}", got_q); end
  endtask

  task automatic test_random();
    int p, len, k;
    for (int it = 0; it < 25; it++) begin
      for (int j = 0; j < 16; j++) in_mem[j] = 8'($urandom_range(97, 122));
      p = 0;
      while (p < 16) begin
        if ($urandom_range(0, 5) == 0) begin in_mem[p] = 8'h00; break; end
        if ($urandom_range(0, 1) == 1) begin
          k = $urandom_range(0, VS - 1);
          len = vocab[k].len();
          for (int j = 0; j < len; j++) if (p + j < 16) in_mem[p + j] = vocab[k][j];
        end else len = $urandom_range(1, 6);
        p += len;
        if (p < 16) in_mem[p] = 8'h00;
        p++;
      end
      build_expect();
      run_stream(1'b1, 1'b1);
      checks++;
      if (got_q != exp_q || int'(tok_count) != exp_q.size() || done_cnt != 1) begin
        errors++;
        $display("FAIL random_%0d got %p cnt=%0d done=%0d exp %p cnt=%0d done=1", it, got_q, tok_count, done_cnt, exp_q, exp_q.size());
      end
    end
  endtask

  initial begin
    setup_vocab();
    load_input("");
    test_reset();
    test_basic_encode();
    test_miss_and_length();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
